// File: rtl/div_seq_controller.sv
// div_seq_controller: control FSM for a WIDTH-bit restoring shift-subtract
// divider. The datapath (dividend/divisor registers, {R,Q} shift pair,
// subtractor, comparator) is external; this block only issues strobes.
//
// Handshake: start is a level request sampled only in IDLE. Requests
// that arrive in any other state are dropped, not queued. done is a
// one-cycle pulse at the end of every operation, including a
// divide-by-zero abort.
//
// Build option: define DIV_ZERO_CHK_EN to add the CHECK/FAULT states.
// These detect a zero divisor before iterating and raise err. Without
// the macro, a zero divisor runs to completion (Q = all ones,
// R = dividend) and err is tied low.
module div_seq_controller #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dvsr_zero,
  input  logic             gte,
  output logic             ldData,
  output logic             clrR,
  output logic             shift,
  output logic             sub,
  output logic [CNT_W-1:0] iter,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_SHIFT = 3'd3,
    S_TEST  = 3'd4,
    S_SUB   = 3'd5,
    S_DONE  = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  // Current state is kept as a named signal so checkers can bind to it.
  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] iter_d;

`ifdef DIV_ZERO_CHK_EN
  logic err_q;
  logic err_d;
`endif

  // Next-state, iteration counter and error flag update rules.
  always_comb begin
    state_d = state;
    iter_d  = iter;
`ifdef DIV_ZERO_CHK_EN
    err_d   = err_q;
`endif
    case (state)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
`ifdef DIV_ZERO_CHK_EN
        err_d   = 1'b0;
        state_d = S_CHECK;
`else
        iter_d  = '0;
        state_d = S_SHIFT;
`endif
      end
`ifdef DIV_ZERO_CHK_EN
      S_CHECK: begin
        if (dvsr_zero) begin
          // err is set on entry to FAULT so it rises together with done.
          err_d   = 1'b1;
          state_d = S_FAULT;
        end else begin
          iter_d  = '0;
          state_d = S_SHIFT;
        end
      end
      S_FAULT: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
`endif
      S_SHIFT: begin
        state_d = S_TEST;
      end
      S_TEST: begin
        if (gte) begin
          state_d = S_SUB;
        end else if (iter == LAST) begin
          state_d = S_DONE;
        end else begin
          iter_d  = iter + 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SUB: begin
        if (iter == LAST) begin
          state_d = S_DONE;
        end else begin
          iter_d  = iter + 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register. Strobes are registered copies of the next state's
  // Moore decode, so each one is glitch-free and exactly tracks the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      iter   <= '0;
      ldData <= 1'b0;
      clrR   <= 1'b0;
      shift  <= 1'b0;
      sub    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      iter   <= iter_d;
      ldData <= (state_d == S_LOAD);
      clrR   <= (state_d == S_LOAD);
      shift  <= (state_d == S_SHIFT);
      sub    <= (state_d == S_SUB);
      busy   <= (state_d == S_LOAD)  || (state_d == S_CHECK) ||
                (state_d == S_SHIFT) || (state_d == S_TEST)  ||
                (state_d == S_SUB);
      done   <= (state_d == S_DONE) || (state_d == S_FAULT);
    end
  end

`ifdef DIV_ZERO_CHK_EN
  // Sticky divide-by-zero flag; cleared only when the next LOAD runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err = err_q;
`else
  // Without the zero check, the divisor-zero status is not consulted.
  logic unused_dvsr_zero;
  assign unused_dvsr_zero = dvsr_zero;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq_controller.sv
// Bench for div_seq_controller (WIDTH=8). It models the external divider
// datapath so the controller's strobes produce a real quotient and
// remainder. Those results are compared against plain integer arithmetic.
module tb_div_seq_controller;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);
`ifdef DIV_ZERO_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int BASE = CHK ? 2 : 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             dvsr_zero;
  logic             gte;
  logic             ldData, clrR, shift, sub, busy, done, err;
  logic [CNT_W-1:0] iter;

  div_seq_controller #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .dvsr_zero(dvsr_zero), .gte(gte),
    .ldData(ldData), .clrR(clrR), .shift(shift), .sub(sub), .iter(iter),
    .busy(busy), .done(done), .err(err)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- datapath model ----------------
  logic [7:0] op_a = 8'd0, op_b = 8'd0;
  logic [8:0] dp_r = 9'd0;
  logic [7:0] dp_q = 8'd0, dp_d = 8'd0;
  int         n_shift = 0, n_sub = 0;

  assign gte       = (dp_r >= {1'b0, dp_d});
  assign dvsr_zero = (dp_d == 8'd0);

  always @(posedge clk) begin
    if (ldData) begin
      dp_q <= op_a;
      dp_d <= op_b;
    end
    if (clrR) dp_r <= 9'd0;
    if (shift) begin
      {dp_r, dp_q} <= {dp_r[7:0], dp_q, 1'b0};
      n_shift <= n_shift + 1;
    end
    if (sub) begin
      dp_r    <= dp_r - {1'b0, dp_d};
      dp_q[0] <= 1'b1;
      n_sub   <= n_sub + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_mis = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input int act, input int expv);
    n_vec++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic check_pop(input string name, input int act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL %s: got %0d expected <empty queue>", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, int'(e));
    end
  endtask

  // Reference: plain integer division plus the documented latency rule.
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    int         lat;
    logic       e;
  } vec_t;

  function automatic vec_t model(input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    v.a = a;
    v.b = b;
    if (b == 8'd0 && CHK) begin
      v.q = a;       // loaded but never shifted
      v.r = 8'd0;    // cleared by LOAD
      v.lat = 2;
      v.e = 1'b1;
    end else begin
      v.q = (b == 8'd0) ? 8'hFF : a / b;
      v.r = (b == 8'd0) ? a : a % b;
      v.lat = 2 * WIDTH + BASE + $countones(v.q);
      v.e = 1'b0;
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // One operation: start is pulsed for edge 0. With noise set, start is
  // randomly toggled for the rest of the busy window.
  task automatic run_vec(input vec_t v, input bit noise, input string tag);
    int sh0, su0, lat, exp_sh, exp_su;
    logic got_e;
    logic [CNT_W-1:0] it_end;
    exp_sh = v.e ? 0 : WIDTH;
    exp_su = v.e ? 0 : $countones(v.q);
    exp_q.push_back(32'(v.q));
    exp_q.push_back(32'(v.r));
    exp_q.push_back(32'(v.lat));
    exp_q.push_back(32'(v.e));
    exp_q.push_back(32'(exp_sh));
    exp_q.push_back(32'(exp_su));
    sh0 = n_shift;
    su0 = n_sub;
    @(negedge clk);
    op_a  = v.a;
    op_b  = v.b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat   = -1;
    got_e = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat   = cyc;
        got_e = err;
        break;
      end
      if (cyc == 1) check({tag, " busy_after_load"}, int'(busy), 1);
      start = (noise && cyc < v.lat) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start  = 1'b0;
    it_end = iter;
    check_pop({tag, " quotient"}, int'(dp_q));
    check_pop({tag, " remainder"}, int'(dp_r[7:0]));
    check_pop({tag, " done_edge"}, lat);
    check_pop({tag, " err"}, int'(got_e));
    check_pop({tag, " shift_count"}, n_shift - sh0);
    check_pop({tag, " sub_count"}, n_sub - su0);
    if (!v.e) check({tag, " iter_final"}, int'(it_end), WIDTH - 1);
    @(posedge clk);
    #1 check({tag, " done_single"}, int'({done, busy}), 0);
    @(posedge clk);
    #1 check({tag, " no_queued_start"}, int'({busy, ldData}), 0);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[5];
  vec_t rv;
  int   ndone, last, phase, n_late;

  initial begin
    tbl[0] = '{8'd200, 8'd7,   8'd28,  8'd4, CHK ? 21 : 20, 1'b0};
    tbl[1] = '{8'd0,   8'd5,   8'd0,   8'd0, CHK ? 18 : 17, 1'b0};
    tbl[2] = '{8'd255, 8'd1,   8'd255, 8'd0, CHK ? 26 : 25, 1'b0};
    tbl[3] = '{8'd13,  8'd0,   CHK ? 8'd13 : 8'd255, CHK ? 8'd0 : 8'd13,
               CHK ? 2 : 25, CHK};
    tbl[4] = '{8'd100, 8'd9,   8'd11,  8'd1, CHK ? 21 : 20, 1'b0};

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_strobes", int'({ldData, clrR, shift, sub, busy, done}), 0);
    check("reset_iter", int'(iter), 0);
    check("reset_err", int'(err), 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);

    // Table-driven vectors.
    for (int i = 0; i < 5; i++) begin
      run_vec(tbl[i], 1'b0, $sformatf("tbl%0d", i));
      if (tbl[i].b == 8'd0) begin
        // The flag is sticky until the next LOAD (the following row).
        repeat (3) @(posedge clk);
        #1 check("err_sticky", int'(err), int'(CHK));
      end
    end

    // Reset in the middle of 200/7: immediate clear, no done afterwards.
    @(negedge clk);
    op_a  = 8'd200;
    op_b  = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_strobes", int'({ldData, clrR, shift, sub, busy, done}), 0);
    check("abort_iter_err", int'({iter, err}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    n_late = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1 if (done || busy) n_late++;
    end
    check("abort_no_done", n_late, 0);
    run_vec(tbl[4], 1'b0, "post_abort");

    // Start held high: back-to-back ops with one IDLE cycle between.
    @(negedge clk);
    op_a  = 8'd200;
    op_b  = 8'd7;
    start = 1'b1;
    ndone = 0;
    last  = -1;
    phase = 0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      @(posedge clk);
      #1;
      if (phase == 1) begin
        check("hold_idle_gap", int'({busy, ldData, done}), 0);
        phase = 2;
      end else if (phase == 2) begin
        check("hold_reload", int'(ldData), 1);
        phase = 0;
      end
      if (done) begin
        ndone++;
        if (last >= 0) check("hold_spacing", cyc - last, tbl[0].lat + 2);
        last  = cyc;
        phase = 1;
        if (ndone == 3) begin
          start = 1'b0;
          break;
        end
      end
    end
    check("hold_done_count", ndone, 3);
    @(posedge clk);
    @(posedge clk);
    #1 check("hold_stops", int'(busy), 0);

    // Randomized operations with start noise during busy.
    for (int i = 0; i < 24; i++) begin
      rv = model(8'($urandom_range(0, 255)),
                 ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
      run_vec(rv, 1'b1, $sformatf("rand%0d_%0d/%0d", i, rv.a, rv.b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/div_seq_controller.md
Name: div_seq_controller

Overview:
- FSM controller that sequences a WIDTH-bit restoring shift-subtract divider datapath (dividend/divisor registers, {R,Q} shift pair, subtractor, comparator).
- Accepts a start pulse, drives load/clear/shift/subtract strobes one bit per iteration, and reports completion with a single-cycle done pulse.
- Detects divide-by-zero and flags it through err.
- The arithmetic itself stays in the datapath; this block is control only.

Parameters:
- WIDTH, 8, operand/quotient width; number of iterations.
- CNT_W, $clog2(WIDTH), width of the iteration counter (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new division; sampled only in IDLE.
- dvsr_zero  input  1  datapath: divisor register == 0 (valid from CHECK onward).
- gte  input  1  datapath: shifted partial remainder >= divisor.
- ldData  output  1  load dividend into Q and divisor into D.
- clrR  output  1  clear remainder register R.
- shift  output  1  shift {R,Q} left by one bit.
- sub  output  1  R <= R - D and Q[0] <= 1.
- iter  output  CNT_W  index of the current iteration (0..WIDTH-1).
- busy  output  1  high from LOAD through the last iteration.
- done  output  1  one-cycle completion pulse.
- err  output  1  divide-by-zero flag; sticky until the next LOAD.

Behaviour:
- Reset: state=IDLE, iter=0, err=0. All strobes, busy and done are 0 immediately (asynchronous).
- Strobe outputs (ldData, clrR, shift, sub, busy, done) are Moore, decoded from state only. err and iter are registered.
- States and transitions:
  - IDLE: start=1 -> LOAD. Otherwise stay.
  - LOAD: ldData=1, clrR=1, busy=1, err<=0 -> CHECK.
  - CHECK: busy=1. dvsr_zero=1 -> FAULT. Otherwise iter<=0 -> SHIFT.
  - SHIFT: shift=1, busy=1 -> TEST.
  - TEST: busy=1.
    - gte=1 -> SUB.
    - gte=0 and iter==WIDTH-1 -> DONE.
    - gte=0 otherwise: iter<=iter+1 -> SHIFT.
  - SUB: sub=1, busy=1. iter==WIDTH-1 -> DONE. Otherwise iter<=iter+1 -> SHIFT.
  - DONE: done=1, busy=0 -> IDLE.
  - FAULT: err<=1, done=1, busy=0 -> IDLE. No shift or sub is ever issued.
- Latency: count the edge that samples start as edge 0.
  - done rises at edge 2*WIDTH + 2 + k, where k = number of 1 bits in the quotient.
  - On fault, done and err rise at edge 2.
- iter never exceeds WIDTH-1. It holds its value in DONE/IDLE and is reset to 0 in CHECK.
- start asserted in any state other than IDLE is ignored; there is no queueing.
- start held high continuously gives back-to-back operations with exactly one IDLE cycle between DONE and the next LOAD.
- rst asserted mid-operation aborts immediately. The result is discarded and no done pulse is produced. The next start after rst deasserts runs normally.
- gte and dvsr_zero are ignored in every state except TEST and CHECK respectively.

Optional Feature:
- Macro: DIV_ZERO_CHK_EN.
- Defined: CHECK and FAULT exist exactly as described above.
- Undefined:
  - LOAD goes directly to SHIFT with iter<=0.
  - dvsr_zero is ignored and err is tied to 0.
  - done rises at edge 2*WIDTH + 1 + k.
  - A zero divisor runs to completion, producing Q=all-ones and R=dividend, per restoring-division semantics.

Test Plan (WIDTH=8, bench models the datapath; DIV_ZERO_CHK_EN defined unless stated):
- 200/7 -> Q=28, R=4; exactly 8 shift and 3 sub pulses; done at edge 21; err=0.
- 0/5 -> Q=0, R=0; zero sub pulses; done at edge 18. Then 255/1 -> Q=255, R=0; done at edge 26.
- Divisor 0 -> err=1 and done=1 at edge 2; no shift or sub. err stays 1 until the next LOAD, which clears it.
- rst pulsed at edge 10 of 200/7 -> all outputs 0 at once and no done. Then 100/9 -> Q=11, R=1; done at edge 21.
- Extra start pulses during busy are ignored. start held high for three operations -> three done pulses, each followed by one IDLE cycle and then LOAD.
- DIV_ZERO_CHK_EN undefined: 200/7 -> done at edge 20; 13/0 -> Q=255, R=13, err=0.
